// File: rtl/uart_alu_pkg.sv
// Shared types and constants for the UART <-> ALU command sequencer.
package uart_alu_pkg;

  localparam int NB_DATA_DEF = 8;
  localparam int NB_OP_DEF   = 6;

  typedef enum logic [2:0] {
    ST_WAIT_A  = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5
  } state_e;

  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_AND = 6'h24;
  localparam logic [5:0] OP_OR  = 6'h25;
  localparam logic [5:0] OP_XOR = 6'h26;
  localparam logic [5:0] OP_SRA = 6'h03;
  localparam logic [5:0] OP_SRL = 6'h02;
  localparam logic [5:0] OP_NOR = 6'h27;

  // States in which an incoming byte cannot be accepted.
  function automatic logic is_busy(input state_e s);
    return (s == ST_EXEC) || (s == ST_SEND) || (s == ST_WAIT_TX);
  endfunction

endpackage

// File: rtl/uart_alu_ctrl_rx_timeout_cnt.sv
// Inter-byte idle counter; o_terminal flags the last cycle a command may stay incomplete.
module rx_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int NB_TMO         = 20
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_terminal
);

  localparam logic [NB_TMO-1:0] LAST = NB_TMO'(TIMEOUT_CYCLES - 1);

  logic [NB_TMO-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear)       cnt_d = '0;
    else if (i_enable) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign o_terminal = (cnt_q == LAST);

endmodule

// File: rtl/uart_alu_ctrl.sv
// Collects A, B, opcode bytes from the UART, drives the ALU, and sends back one result byte.
module uart_alu_ctrl
  import uart_alu_pkg::*;
#(
  parameter int NB_DATA        = NB_DATA_DEF,
  parameter int NB_OP          = NB_OP_DEF,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int NB_TMO         = 20
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done_tick,
  input  logic               i_tx_done_tick,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_timeout,
  output logic               o_overrun
);

  state_e             state_q, state_d;
  logic [NB_DATA-1:0] stage_a_q, stage_a_d, stage_b_q, stage_b_d;
  logic [NB_DATA-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, tx_data_q, tx_data_d;
  logic [NB_OP-1:0]   alu_op_q, alu_op_d;
  logic               tx_start_q, tx_start_d, timeout_q, timeout_d, overrun_q, overrun_d;
  logic               waiting, tmo_terminal;

  // The idle counter only runs between bytes of a partially received command.
  assign waiting = (state_q == ST_WAIT_B) || (state_q == ST_WAIT_OP);

  rx_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .NB_TMO        (NB_TMO)
  ) u_tmo (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (!waiting || i_rx_done_tick || tmo_terminal),
    .i_enable  (waiting),
    .o_terminal(tmo_terminal)
  );

  always_comb begin
    // NOTE: every _d gets a default first so no path through the case leaves it unassigned (no latches).
    state_d    = state_q;
    stage_a_d  = stage_a_q;
    stage_b_d  = stage_b_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    timeout_d  = 1'b0;
    overrun_d  = i_rx_done_tick && is_busy(state_q);

    case (state_q)
      ST_WAIT_A: if (i_rx_done_tick) begin
        stage_a_d = i_rx_data;
        state_d   = ST_WAIT_B;
      end
      ST_WAIT_B: if (i_rx_done_tick) begin
        stage_b_d = i_rx_data;
        state_d   = ST_WAIT_OP;
      end else if (tmo_terminal) begin
        timeout_d = 1'b1;
        state_d   = ST_WAIT_A;
      end
      // Operands and opcode change together so the ALU never sees a mixed command.
      ST_WAIT_OP: if (i_rx_done_tick) begin
        alu_a_d  = stage_a_q;
        alu_b_d  = stage_b_q;
        alu_op_d = i_rx_data[NB_OP-1:0];
        state_d  = ST_EXEC;
      end else if (tmo_terminal) begin
        timeout_d = 1'b1;
        state_d   = ST_WAIT_A;
      end
      ST_EXEC: begin
        tx_data_d  = i_alu_result;
        tx_start_d = 1'b1;
        state_d    = ST_SEND;
      end
      ST_SEND:    state_d = ST_WAIT_TX;
      ST_WAIT_TX: if (i_tx_done_tick) state_d = ST_WAIT_A;
      default:    state_d = ST_WAIT_A;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= ST_WAIT_A;
      stage_a_q  <= '0;
      stage_b_q  <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      timeout_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q    <= state_d;
      stage_a_q  <= stage_a_d;
      stage_b_q  <= stage_b_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      timeout_q  <= timeout_d;
      overrun_q  <= overrun_d;
    end
  end

  assign o_alu_a    = alu_a_q;
  assign o_alu_b    = alu_b_q;
  assign o_alu_op   = alu_op_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_busy     = is_busy(state_q);
  assign o_timeout  = timeout_q;
  assign o_overrun  = overrun_q;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Directed bench for uart_alu_ctrl; the bench plays the UART and the ALU.
module tb_uart_alu_ctrl;
  import uart_alu_pkg::*;

  localparam int TMO = 100;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b0;
  logic [7:0] i_rx_data = '0;
  logic       i_rx_done_tick = 1'b0;
  logic       i_tx_done_tick = 1'b0;
  logic [7:0] i_alu_result;
  logic [7:0] o_alu_a, o_alu_b, o_tx_data;
  logic [5:0] o_alu_op;
  logic       o_tx_start, o_busy, o_timeout, o_overrun;

  int vec_cnt = 0;
  int err_cnt = 0;

  uart_alu_ctrl #(.NB_DATA(8), .NB_OP(6), .TIMEOUT_CYCLES(TMO), .NB_TMO(7)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_rx_data(i_rx_data),
    .i_rx_done_tick(i_rx_done_tick), .i_tx_done_tick(i_tx_done_tick),
    .i_alu_result(i_alu_result), .o_alu_a(o_alu_a), .o_alu_b(o_alu_b),
    .o_alu_op(o_alu_op), .o_tx_data(o_tx_data), .o_tx_start(o_tx_start),
    .o_busy(o_busy), .o_timeout(o_timeout), .o_overrun(o_overrun)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SRA:  return 8'($signed(a) >>> b);
      OP_SRL:  return a >> b;
      OP_NOR:  return ~(a | b);
      default: return 8'h00;
    endcase
  endfunction

  assign i_alu_result = alu_model(o_alu_a, o_alu_b, o_alu_op);

  // Byte tick lasts one cycle; returns 1 ns into the cycle after the tick.
  task automatic send_byte(input logic [7:0] b);
    @(posedge i_clk); #1;
    i_rx_data = b; i_rx_done_tick = 1'b1;
    @(posedge i_clk); #1;
    i_rx_done_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    send_byte(a); idle(2);
    send_byte(b); idle(2);
    send_byte(op);
  endtask

  task automatic tx_done();
    @(posedge i_clk); #1; i_tx_done_tick = 1'b1;
    @(posedge i_clk); #1; i_tx_done_tick = 1'b0;
  endtask

  task automatic test_reset;
    i_reset = 1'b1; #3;
    vec_cnt++; if ({o_alu_a, o_alu_b, o_alu_op, o_tx_data} !== 30'h0) begin err_cnt++; $display("FAIL reset_data: got %h, expected 0", {o_alu_a, o_alu_b, o_alu_op, o_tx_data}); end
    vec_cnt++; if ({o_tx_start, o_busy, o_timeout, o_overrun} !== 4'h0) begin err_cnt++; $display("FAIL reset_flags: got %b, expected 0000", {o_tx_start, o_busy, o_timeout, o_overrun}); end
    @(negedge i_clk); i_reset = 1'b0;
  endtask

  task automatic test_basic;
    send_byte(8'h05); idle(10); send_byte(8'h03); idle(10); send_byte(8'h20);
    @(negedge i_clk);
    vec_cnt++; if (o_alu_a !== 8'h05) begin err_cnt++; $display("FAIL basic_alu_a: got %h, expected 05", o_alu_a); end
    vec_cnt++; if (o_alu_b !== 8'h03) begin err_cnt++; $display("FAIL basic_alu_b: got %h, expected 03", o_alu_b); end
    vec_cnt++; if (o_alu_op !== 6'h20) begin err_cnt++; $display("FAIL basic_alu_op: got %h, expected 20", o_alu_op); end
    vec_cnt++; if (o_busy !== 1'b1 || o_tx_start !== 1'b0) begin err_cnt++; $display("FAIL basic_exec_flags: got busy=%b start=%b, expected 1 0", o_busy, o_tx_start); end
    @(negedge i_clk);
    vec_cnt++; if (o_tx_data !== 8'h08) begin err_cnt++; $display("FAIL basic_tx_data: got %h, expected 08", o_tx_data); end
    vec_cnt++; if (o_tx_start !== 1'b1) begin err_cnt++; $display("FAIL basic_tx_start: got %b, expected 1", o_tx_start); end
    @(negedge i_clk);
    vec_cnt++; if (o_tx_start !== 1'b0) begin err_cnt++; $display("FAIL basic_tx_start_len: got %b, expected 0", o_tx_start); end
    idle(5); @(negedge i_clk);
    vec_cnt++; if (o_busy !== 1'b1) begin err_cnt++; $display("FAIL basic_busy_wait: got %b, expected 1", o_busy); end
    tx_done(); @(negedge i_clk);
    vec_cnt++; if (o_busy !== 1'b0) begin err_cnt++; $display("FAIL basic_busy_done: got %b, expected 0", o_busy); end
  endtask

  task automatic test_opmask;
    issue(8'h10, 8'h01, 8'hE2);
    @(negedge i_clk);
    vec_cnt++; if (o_alu_op !== 6'h22) begin err_cnt++; $display("FAIL opmask_op: got %h, expected 22", o_alu_op); end
    @(negedge i_clk);
    vec_cnt++; if (o_tx_data !== 8'h0F) begin err_cnt++; $display("FAIL opmask_tx_data: got %h, expected 0f", o_tx_data); end
    tx_done();
  endtask

  task automatic test_timeout;
    int pulses = 0;
    int at = 0;
    send_byte(8'h05);
    for (int i = 1; i <= TMO + 5; i++) begin
      @(negedge i_clk);
      if (o_timeout === 1'b1) begin pulses++; at = i; end
    end
    vec_cnt++; if (pulses !== 1) begin err_cnt++; $display("FAIL timeout_pulses: got %0d, expected 1", pulses); end
    vec_cnt++; if (at !== TMO + 1) begin err_cnt++; $display("FAIL timeout_cycle: got %0d, expected %0d", at, TMO + 1); end
    vec_cnt++; if ({o_alu_a, o_alu_b, o_alu_op} !== {8'h10, 8'h01, 6'h22}) begin err_cnt++; $display("FAIL timeout_alu_kept: got %h %h %h, expected 10 01 22", o_alu_a, o_alu_b, o_alu_op); end
    issue(8'h07, 8'h01, 8'h22);
    @(negedge i_clk); @(negedge i_clk);
    vec_cnt++; if (o_tx_data !== 8'h06 || o_tx_start !== 1'b1) begin err_cnt++; $display("FAIL timeout_next_cmd: got %h start=%b, expected 06 1", o_tx_data, o_tx_start); end
    tx_done();
  endtask

  task automatic test_overrun;
    issue(8'h03, 8'h04, 8'h25);
    @(negedge i_clk); @(negedge i_clk);
    vec_cnt++; if (o_tx_data !== 8'h07) begin err_cnt++; $display("FAIL ovr_tx_data: got %h, expected 07", o_tx_data); end
    send_byte(8'hAA);
    @(negedge i_clk);
    vec_cnt++; if (o_overrun !== 1'b1 || o_busy !== 1'b1) begin err_cnt++; $display("FAIL ovr_pulse: got ovr=%b busy=%b, expected 1 1", o_overrun, o_busy); end
    @(negedge i_clk);
    vec_cnt++; if (o_overrun !== 1'b0 || o_busy !== 1'b1) begin err_cnt++; $display("FAIL ovr_clear: got ovr=%b busy=%b, expected 0 1", o_overrun, o_busy); end
    @(posedge i_clk); #1;
    i_rx_data = 8'h55; i_rx_done_tick = 1'b1; i_tx_done_tick = 1'b1;
    @(posedge i_clk); #1;
    i_rx_done_tick = 1'b0; i_tx_done_tick = 1'b0;
    @(negedge i_clk);
    vec_cnt++; if (o_overrun !== 1'b1 || o_busy !== 1'b0) begin err_cnt++; $display("FAIL ovr_with_txdone: got ovr=%b busy=%b, expected 1 0", o_overrun, o_busy); end
    issue(8'h0C, 8'h0A, 8'h24);
    @(negedge i_clk);
    vec_cnt++; if ({o_alu_a, o_alu_b} !== 16'h0C0A) begin err_cnt++; $display("FAIL ovr_next_ab: got %h %h, expected 0c 0a", o_alu_a, o_alu_b); end
    @(negedge i_clk);
    vec_cnt++; if (o_tx_data !== 8'h08) begin err_cnt++; $display("FAIL ovr_next_tx: got %h, expected 08", o_tx_data); end
    tx_done();
  endtask

  task automatic test_reset_midcmd;
    send_byte(8'h01); idle(2); send_byte(8'h02);
    #2; i_reset = 1'b1; #1;
    vec_cnt++; if ({o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_busy} !== 31'h0) begin err_cnt++; $display("FAIL rst_waitop: got %h, expected 0", {o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_busy}); end
    @(negedge i_clk); i_reset = 1'b0;
    issue(8'h0F, 8'hF0, 8'h26);
    @(negedge i_clk); @(negedge i_clk);
    vec_cnt++; if (o_tx_data !== 8'hFF || o_tx_start !== 1'b1) begin err_cnt++; $display("FAIL rst_fresh_xor: got %h start=%b, expected ff 1", o_tx_data, o_tx_start); end
    @(posedge i_clk); #3; i_reset = 1'b1; #1;
    vec_cnt++; if ({o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_busy, o_tx_start} !== 32'h0) begin err_cnt++; $display("FAIL rst_waittx: got %h, expected 0", {o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_busy, o_tx_start}); end
    @(negedge i_clk); i_reset = 1'b0;
    issue(8'h80, 8'h01, 8'h03);
    @(negedge i_clk); @(negedge i_clk);
    vec_cnt++; if (o_tx_data !== 8'hC0) begin err_cnt++; $display("FAIL rst_fresh_sra: got %h, expected c0", o_tx_data); end
    tx_done(); @(negedge i_clk);
    vec_cnt++; if (o_busy !== 1'b0) begin err_cnt++; $display("FAIL rst_fresh_done: got %b, expected 0", o_busy); end
  endtask

  task automatic test_timeout_edge;
    send_byte(8'h09);
    idle(TMO - 2);
    send_byte(8'h04);
    @(negedge i_clk);
    vec_cnt++; if (o_timeout !== 1'b0) begin err_cnt++; $display("FAIL edge_timeout: got %b, expected 0", o_timeout); end
    send_byte(8'h20);
    @(negedge i_clk);
    vec_cnt++; if ({o_alu_a, o_alu_b} !== 16'h0904) begin err_cnt++; $display("FAIL edge_ab: got %h %h, expected 09 04", o_alu_a, o_alu_b); end
    @(negedge i_clk);
    vec_cnt++; if (o_tx_data !== 8'h0D) begin err_cnt++; $display("FAIL edge_tx_data: got %h, expected 0d", o_tx_data); end
    tx_done();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_opmask();
    test_timeout();
    test_overrun();
    test_reset_midcmd();
    test_timeout_edge();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
